// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared widths, limits and BCD digit step for the frequency meter
package freq_meter_pkg;
   localparam int BCD_W = 4;
   localparam int N_DIGITS = 4;
   localparam logic [BCD_W*N_DIGITS-1:0] BCD_MAX = 16'h9999;
   localparam int GATE_DEFAULT = 50000;
   typedef logic [BCD_W-1:0] digit_t;
   function automatic digit_t digit_next(input digit_t q, input logic inc);
      return inc ? ((q == 4'd9) ? '0 : q + 1'b1) : q;
   endfunction
endpackage

// File: rtl/freq_meter_if.sv
// freq_meter_if: measured input and latched BCD result bundle
interface freq_meter_if;
   import freq_meter_pkg::*;
   logic fin;
   logic [BCD_W*N_DIGITS-1:0] bcd;
   logic ovf;
   logic valid;
   modport master (output fin, input bcd, ovf, valid);
   modport slave (input fin, output bcd, ovf, valid);
endinterface

// File: rtl/freq_meter_bcd_digit.sv
// bcd_digit: mod-10 counter digit with synchronous clear and terminal-count flag
module bcd_digit
   import freq_meter_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   clr_i,
   input  logic   inc_i,
   output digit_t q_o,
   output logic   tc_o
);
   digit_t cnt_q, cnt_d;
   always_comb cnt_d = clr_i ? '0 : digit_next(cnt_q, inc_i);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
   assign q_o = cnt_q;
   assign tc_o = cnt_q == 4'd9;
endmodule

// File: rtl/freq_meter.sv
// freq_meter: counts fin rising edges over a GATE-cycle window and latches a saturating 4-digit BCD result
module freq_meter
   import freq_meter_pkg::*;
#(
   parameter int GATE = GATE_DEFAULT
) (
   input logic         clk,
   input logic         rst,
   freq_meter_if.slave bus
);
   localparam int GW = $clog2(GATE);
   localparam logic [GW-1:0] GLAST = GW'(GATE - 1);
   logic s1_q, s2_q, s3_q;
   logic [GW-1:0] gcnt_q, gcnt_d;
   logic sat_q, sat_d, ovf_q, ovf_d, valid_q;
   logic [BCD_W*N_DIGITS-1:0] bcd_q, bcd_d, cnt, cnt_nxt;
   logic [N_DIGITS-1:0] tc, inc;
   logic rise, win_end, full, sat_cond;
   assign rise = s2_q & ~s3_q;
   assign win_end = gcnt_q == GLAST;
   assign full = cnt == BCD_MAX;
   assign sat_cond = rise & full;
   for (genvar i = 0; i < N_DIGITS; i++) begin : g_dig
      // a digit steps only when every lower digit is at 9
      localparam logic [N_DIGITS-1:0] LOW = N_DIGITS'((1 << i) - 1);
      assign inc[i] = rise & ~full & (&(tc | ~LOW));
      bcd_digit u_dig (
         .clk   (clk),
         .rst   (rst),
         .clr_i (win_end),
         .inc_i (inc[i]),
         .q_o   (cnt[i*BCD_W +: BCD_W]),
         .tc_o  (tc[i])
      );
      assign cnt_nxt[i*BCD_W +: BCD_W] = digit_next(cnt[i*BCD_W +: BCD_W], inc[i]);
   end
   always_comb begin
      gcnt_d = win_end ? '0 : gcnt_q + 1'b1;
      sat_d = ~win_end & (sat_q | sat_cond);
      bcd_d = win_end ? cnt_nxt : bcd_q;
      ovf_d = win_end ? (sat_q | sat_cond) : ovf_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
         gcnt_q <= '0;
         sat_q <= 1'b0;
         bcd_q <= '0;
         ovf_q <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         s1_q <= bus.fin;
         s2_q <= s1_q;
         s3_q <= s2_q;
         gcnt_q <= gcnt_d;
         sat_q <= sat_d;
         bcd_q <= bcd_d;
         ovf_q <= ovf_d;
         valid_q <= win_end;
      end
   end
   assign bus.bcd = bcd_q;
   assign bus.ovf = ovf_q;
   assign bus.valid = valid_q;
endmodule
